eu_icon_tx_port: RTL and testbench

Egress stage between one execution unit's result output and eu_interconnect. Buffers completed results in a small FIFO and requests an interconnect channel for the head entry. It then drives the granted channel for exactly one cycle and retires the entry. Each unit instantiates one of these; its per-channel drive enables and channel payload feed the interconnect's shared ports.

---
 rtl/eu_icon_tx_port_pkg.sv | 28 ++
 rtl/eu_sync_fifo.sv | 63 ++++++
 rtl/eu_icon_tx_port.sv | 141 ++++++++++++++
 tb/tb_eu_icon_tx_port.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eu_icon_tx_port_pkg.sv
// -----------------------------------------------------------------------------
// exec_unit_dtypes
//   Shared types for execution-unit egress ports and the interconnect.
//   - type_icon_channel : one interconnect channel payload {valid, tag, data}
//   - type_icon_tx_state: egress port sequencing states
//   - ICON_* widths     : default widths. A packed struct cannot take module
//                         parameters, so every port that carries a channel must
//                         be built with these widths.
// -----------------------------------------------------------------------------
package exec_unit_dtypes;

  localparam int ICON_DATA_WIDTH = 32;
  localparam int ICON_TAG_WIDTH  = 6;
  localparam int ICON_AGE_WIDTH  = 4;

  typedef struct packed {
    logic                      valid;
    logic [ICON_TAG_WIDTH-1:0]  tag;
    logic [ICON_DATA_WIDTH-1:0] data;
  } type_icon_channel;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2
  } type_icon_tx_state;

endpackage

// File: rtl/eu_sync_fifo.sv
// -----------------------------------------------------------------------------
// eu_sync_fifo
//   Single-clock FIFO with first-word-fall-through head output.
//   Ports:
//     clk, reset     : clock, synchronous active-high reset (empties FIFO)
//     push, wdata    : write request and data; ignored while full
//     pop            : retire head entry; ignored while empty
//     head           : current head entry (valid when !empty)
//     count          : occupancy, 0..DEPTH
//     full, empty    : occupancy flags
//   DEPTH must be a power of two so pointers wrap naturally.
// -----------------------------------------------------------------------------
module eu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; only pointers/count define
  // validity, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/eu_icon_tx_port.sv
// -----------------------------------------------------------------------------
// eu_icon_tx_port
//   Egress stage from one execution unit into eu_interconnect. Results are
//   buffered in a FIFO; the head entry requests a channel, drives the granted
//   channel for exactly one cycle, then retires.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     i_res_valid/o_res_ready, i_res_tag, i_res_data : result push interface
//     o_req, o_req_age    : channel request and its age priority (larger wins)
//     i_grant             : one-hot grant from the interconnect arbiter
//     o_ch_en, o_ch       : one-hot channel drive enable and payload
//     o_err               : sticky protocol error (bad or unsolicited grant)
//     o_count             : FIFO occupancy
// -----------------------------------------------------------------------------
module eu_icon_tx_port
  import exec_unit_dtypes::*;
#(
  parameter int DATA_WIDTH   = ICON_DATA_WIDTH,
  parameter int TAG_WIDTH    = ICON_TAG_WIDTH,
  parameter int DEPTH        = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int AGE_WIDTH    = ICON_AGE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_res_valid,
  output logic                      o_res_ready,
  input  logic [TAG_WIDTH-1:0]      i_res_tag,
  input  logic [DATA_WIDTH-1:0]     i_res_data,
  output logic                      o_req,
  output logic [AGE_WIDTH-1:0]      o_req_age,
  input  logic [NUM_CHANNELS-1:0]   i_grant,
  output logic [NUM_CHANNELS-1:0]   o_ch_en,
  output type_icon_channel          o_ch,
  output logic                      o_err,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = TAG_WIDTH + DATA_WIDTH;

  type_icon_tx_state state_q, state_d;
  logic [AGE_WIDTH-1:0] age_q;
  logic [IDX_W-1:0]     ch_idx_q;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 grant_multi;
  logic                 out_of_reset_q;
  logic                 err_q;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        head_entry;

  // Ready is held low for the first cycle after reset so every output is
  // zero while reset is applied; afterwards it tracks registered occupancy.
  assign o_res_ready = out_of_reset_q && !fifo_full;
  assign push        = i_res_valid && o_res_ready;
  assign pop         = (state_q == DRIVE) && !fifo_empty;
  assign o_err       = err_q;

  eu_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({i_res_tag, i_res_data}),
    .pop   (pop),
    .head  (head_entry),
    .count (o_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lowest set grant bit wins; x & (x-1) is nonzero iff more than one bit set.
  assign grant_any   = |i_grant;
  assign grant_multi = |(i_grant & (i_grant - NUM_CHANNELS'(1)));

  always_comb begin
    grant_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (i_grant[i]) grant_idx = IDX_W'(i);
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    o_req     = 1'b0;
    o_req_age = '0;
    o_ch_en   = '0;
    o_ch      = '0;
    unique case (state_q)
      IDLE: begin
        if (push) state_d = REQ;
      end
      REQ: begin
        o_req     = 1'b1;
        o_req_age = age_q;
        if (grant_any) state_d = DRIVE;
      end
      DRIVE: begin
        o_ch_en    = NUM_CHANNELS'(1) << ch_idx_q;
        o_ch.valid = 1'b1;
        o_ch.tag   = head_entry[EW-1 -: TAG_WIDTH];
        o_ch.data  = head_entry[DATA_WIDTH-1:0];
        // Occupancy after this pop plus any same-cycle push.
        state_d    = (o_count > CW'(1) || push) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      age_q          <= '0;
      ch_idx_q       <= '0;
      err_q          <= 1'b0;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_of_reset_q <= 1'b1;
      if (state_q == REQ) begin
        if (grant_any) ch_idx_q <= grant_idx;
        if (age_q != '1) age_q <= age_q + AGE_WIDTH'(1);
      end else if (state_q == DRIVE) begin
        age_q <= '0;
      end
      // Multi-bit grant while requesting, or any grant while not requesting.
      if ((state_q == REQ && grant_multi) || (state_q != REQ && grant_any))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eu_icon_tx_port.sv
// -----------------------------------------------------------------------------
// tb_eu_icon_tx_port
//   Directed scenarios followed by randomized traffic. A reference model keeps
//   the buffer occupancy, whether the head is waiting or being driven, its
//   age, and the sticky error. Accepted results and granted channels are queued
//   as expectations; a monitor compares them whenever the port drives.
// -----------------------------------------------------------------------------
module tb_eu_icon_tx_port;
  import exec_unit_dtypes::*;

  localparam int DW      = 32;
  localparam int TW      = 6;
  localparam int DEPTH   = 4;
  localparam int NCH     = 2;
  localparam int AW      = 4;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic              clk;
  logic              reset;
  logic              i_res_valid;
  logic              o_res_ready;
  logic [TW-1:0]     i_res_tag;
  logic [DW-1:0]     i_res_data;
  logic              o_req;
  logic [AW-1:0]     o_req_age;
  logic [NCH-1:0]    i_grant;
  logic [NCH-1:0]    o_ch_en;
  type_icon_channel  o_ch;
  logic              o_err;
  logic [$clog2(DEPTH):0] o_count;

  eu_icon_tx_port #(
    .DATA_WIDTH   (DW),
    .TAG_WIDTH    (TW),
    .DEPTH        (DEPTH),
    .NUM_CHANNELS (NCH),
    .AGE_WIDTH    (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_res_valid (i_res_valid),
    .o_res_ready (o_res_ready),
    .i_res_tag   (i_res_tag),
    .i_res_data  (i_res_data),
    .o_req       (o_req),
    .o_req_age   (o_req_age),
    .i_grant     (i_grant),
    .o_ch_en     (o_ch_en),
    .o_ch        (o_ch),
    .o_err       (o_err),
    .o_count     (o_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_size;      // entries buffered
  int  m_drv;       // channel being driven this cycle, -1 when not driving
  int  m_age;       // cycles the head has spent requesting, saturated
  bit  m_err;
  bit  m_rdy;       // port out of reset long enough to accept
  bit  started = 0;
  logic [TW+DW-1:0] exp_q[$];
  int               ch_q[$];

  function automatic int lowest_bit(input logic [NCH-1:0] g);
    for (int i = 0; i < NCH; i++) if (g[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit acc;
    started = 1;
    if (reset) begin
      m_size = 0; m_drv = -1; m_age = 0; m_err = 0; m_rdy = 0;
      exp_q.delete();
      ch_q.delete();
    end else begin
      acc = i_res_valid && m_rdy && (m_size < DEPTH);
      if (m_drv >= 0) begin
        m_size--;
        m_drv = -1;
        m_age = 0;
        if (i_grant != 0) m_err = 1;
      end else if (m_size > 0) begin
        if (i_grant != 0) begin
          m_drv = lowest_bit(i_grant);
          ch_q.push_back(m_drv);
          if ($countones(i_grant) != 1) m_err = 1;
        end
        m_age = (m_age < AGE_MAX) ? m_age + 1 : AGE_MAX;
      end else if (i_grant != 0) begin
        m_err = 1;
      end
      if (acc) begin
        m_size++;
        exp_q.push_back({i_res_tag, i_res_data});
      end
      m_rdy = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (started) begin
      bit m_req;
      m_req = (m_size > 0) && (m_drv < 0);
      check("count", 64'(o_count), 64'(m_size));
      check("res_ready", 64'(o_res_ready), 64'(m_rdy && (m_size < DEPTH)));
      check("req", 64'(o_req), 64'(m_req));
      if (m_req) check("req_age", 64'(o_req_age), 64'(m_age));
      check("err", 64'(o_err), 64'(m_err));
      check("ch_en", 64'(o_ch_en), (m_drv >= 0) ? 64'(1 << m_drv) : 64'd0);
      if (o_ch_en != '0) begin
        if (exp_q.size() == 0 || ch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drive: got ch_en 0x%0h expected no drive (t=%0t)", o_ch_en, $time);
        end else begin
          logic [TW+DW-1:0] p;
          int               c;
          p = exp_q.pop_front();
          c = ch_q.pop_front();
          check("drive_payload", 64'({o_ch.tag, o_ch.data}), 64'(p));
          check("drive_valid", 64'(o_ch.valid), 64'd1);
          check("drive_channel", 64'(o_ch_en), 64'(1 << c));
        end
      end else begin
        check("idle_channel", 64'(o_ch), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [TW-1:0] t, input logic [DW-1:0] d,
                     input logic [NCH-1:0] g, input bit r = 1'b0);
    @(negedge clk);
    reset       = r;
    i_res_valid = v;
    i_res_tag   = t;
    i_res_data  = d;
    i_grant     = g;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_res_valid = 1'b0; i_res_tag = '0; i_res_data = '0; i_grant = '0;
    repeat (3) cyc(1'b0, '0, '0, '0, 1'b1);
    idle(1);   // ready rises one cycle after reset drops

    // Single result: age 0,1,2 while waiting, then drive on channel 1.
    cyc(1'b1, 6'd5, 32'hDEADBEEF, '0);
    idle(3);
    cyc(1'b0, '0, '0, 2'b10);
    idle(2);

    // Fill to full; fifth push is dropped; drain in order.
    for (int i = 0; i < 5; i++) cyc(1'b1, TW'(i), 32'h1000 + i, '0);
    repeat (4) begin
      cyc(1'b0, '0, '0, 2'b01);
      idle(1);
    end
    idle(2);

    // Push during DRIVE: count unchanged, back to REQ, new entry driven next.
    cyc(1'b1, 6'd7, 32'hAAAA_0007, '0);
    cyc(1'b0, '0, '0, 2'b01);
    cyc(1'b1, 6'd9, 32'hBBBB_0009, '0);
    cyc(1'b0, '0, '0, 2'b10);
    idle(2);

    // Multi-bit grant: channel 0 driven, sticky error.
    cyc(1'b1, 6'd3, 32'hCCCC_0003, '0);
    cyc(1'b0, '0, '0, 2'b11);
    idle(4);

    // Reset clears error; age saturates; reset during DRIVE aborts it.
    cyc(1'b0, '0, '0, '0, 1'b1);
    idle(1);
    cyc(1'b1, 6'd1, 32'hEEEE_0001, '0);
    idle(20);
    cyc(1'b0, '0, '0, 2'b10);
    cyc(1'b0, '0, '0, '0, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [NCH-1:0] g;
      bit r;
      r = ($urandom_range(0, 99) == 0);
      if (m_size > 0 && m_drv < 0 && $urandom_range(0, 2) != 0)
        g = ($urandom_range(0, 9) == 0) ? 2'b11 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      else
        g = ($urandom_range(0, 49) == 0) ? 2'b01 : 2'b00;
      cyc(1'($urandom_range(0, 1)), TW'($urandom), DW'($urandom), g, r);
    end

    // Drain whatever remains.
    repeat (12) begin
      cyc(1'b0, '0, '0, (m_size > 0 && m_drv < 0) ? 2'b01 : 2'b00);
    end
    idle(1);
    @(negedge clk);
    check("drain_expected_results", 64'(exp_q.size()), 64'd0);
    check("drain_expected_channels", 64'(ch_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
